vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 54 +++++
 rtl/vga_axis_counter.sv | 66 ++++++
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing presets and decode helpers for the VGA raster generator.
// Presets assume a 50 MHz board clock.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FRONT,
        REG_SYNC,
        REG_BACK
    } region_e;

    // 640x480@60: 25 MHz pixel clock, negative syncs
    localparam int VGA640_H_VISIBLE = 640;
    localparam int VGA640_H_FRONT   = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BACK    = 48;
    localparam int VGA640_V_VISIBLE = 480;
    localparam int VGA640_V_FRONT   = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BACK    = 33;
    localparam int VGA640_CLK_DIV   = 2;
    localparam bit VGA640_HS_POL    = 1'b0;
    localparam bit VGA640_VS_POL    = 1'b0;

    // 800x600@72: 50 MHz pixel clock, positive syncs
    localparam int SVGA800_H_VISIBLE = 800;
    localparam int SVGA800_H_FRONT   = 56;
    localparam int SVGA800_H_SYNC    = 120;
    localparam int SVGA800_H_BACK    = 64;
    localparam int SVGA800_V_VISIBLE = 600;
    localparam int SVGA800_V_FRONT   = 37;
    localparam int SVGA800_V_SYNC    = 6;
    localparam int SVGA800_V_BACK    = 23;
    localparam int SVGA800_CLK_DIV   = 1;
    localparam bit SVGA800_HS_POL    = 1'b1;
    localparam bit SVGA800_VS_POL    = 1'b1;

    function automatic int axis_total(int visible, int front, int sync, int back);
        return visible + front + sync + back;
    endfunction

    function automatic region_e region_decode(int pos, int visible, int front, int sync);
        if (pos < visible) begin
            return REG_ACTIVE;
        end else if (pos < visible + front) begin
            return REG_FRONT;
        end else if (pos < visible + front + sync) begin
            return REG_SYNC;
        end else begin
            return REG_BACK;
        end
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active/sync
// decode taken from the next-state count so decode and count stay aligned.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE  = 640,
    parameter int FRONT    = 16,
    parameter int SYNC     = 96,
    parameter int BACK     = 48,
    parameter bit SYNC_POL = 1'b0,
    parameter int W        = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         en,
    output logic         wrap,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         active,
    output logic         sync
);

    localparam int           TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [W-1:0] LAST  = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    logic         active_q, active_d;
    logic         sync_q, sync_d;
    region_e      region_d;

    always_comb begin
        // NOTE: every always_comb output is assigned on every path; a missing
        // branch would infer a latch.
        wrap = en && (count_q == LAST);
        if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end else begin
            count_d = count_q;
        end
        region_d = region_decode(int'(count_d), VISIBLE, FRONT, SYNC);
        active_d = (region_d == REG_ACTIVE);
        sync_d   = (region_d == REG_SYNC) ? SYNC_POL : !SYNC_POL;
    end

    // NOTE: reset is synchronous, so it only takes effect on a clock edge;
    // state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q  <= LAST;
            active_q <= 1'b0;
            sync_q   <= !SYNC_POL;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_q   <= sync_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign active     = active_q;
    assign sync       = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe divider, horizontal/vertical
// axes, look-ahead visibility, line/frame markers and a frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int  H_VISIBLE = 640,
    parameter int  H_FRONT   = 16,
    parameter int  H_SYNC    = 96,
    parameter int  H_BACK    = 48,
    parameter int  V_VISIBLE = 480,
    parameter int  V_FRONT   = 10,
    parameter int  V_SYNC    = 2,
    parameter int  V_BACK    = 33,
    parameter bit  HS_POL    = 1'b0,
    parameter bit  VS_POL    = 1'b0,
    parameter int  CLK_DIV   = 2,
    parameter int  PRE_PIX   = 1,
    localparam int H_TOTAL   = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL   = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic          pixel_en,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_n,
    output logic          pre_visible,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Is the pixel PRE_PIX ahead of (xn, yn) inside the active area?
    function automatic logic pre_active(int xn, int yn);
        int p;
        int l;
        p = xn + PRE_PIX;
        l = yn;
        if (p >= H_TOTAL) begin
            p = p - H_TOTAL;
            l = (yn + 1 == V_TOTAL) ? 0 : yn + 1;
        end
        return (p < H_VISIBLE) && (l < V_VISIBLE);
    endfunction

    localparam logic PRE_RESET = pre_active(H_TOTAL - 1, V_TOTAL - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          pixel_en_q, pixel_en_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          first_wrap_q, first_wrap_d;
    logic          pre_visible_q, pre_visible_d;

    logic          h_wrap, v_wrap, h_active, v_active;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .SYNC_POL(HS_POL),
        .W       (XW)
    ) u_h_axis (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (tick),
        .wrap      (h_wrap),
        .count     (x_q),
        .count_next(x_d),
        .active    (h_active),
        .sync      (hsync)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .SYNC_POL(VS_POL),
        .W       (YW)
    ) u_v_axis (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (h_wrap),
        .wrap      (v_wrap),
        .count     (y_q),
        .count_next(y_d),
        .active    (v_active),
        .sync      (vsync)
    );

    always_comb begin
        tick          = (div_q == DW'(CLK_DIV - 1));
        div_d         = tick ? '0 : div_q + 1'b1;
        pixel_en_d    = tick;
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
        first_wrap_d  = tick ? 1'b0 : first_wrap_q;
        pre_visible_d = pre_active(int'(x_d), int'(y_d));
        // The wrap out of reset only lands on (0,0); it is not a completed frame.
        frame_count_d = (v_wrap && !first_wrap_q) ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_q         <= '0;
            pixel_en_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            first_wrap_q  <= 1'b1;
            pre_visible_q <= PRE_RESET;
        end else begin
            div_q         <= div_d;
            pixel_en_q    <= pixel_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            first_wrap_q  <= first_wrap_d;
            pre_visible_q <= pre_visible_d;
        end
    end

    assign pixel_en    = pixel_en_q;
    assign blank_n     = h_active & v_active;
    assign pre_visible = pre_visible_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
